// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone round-robin arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_ERR   = 2'd2,
    S_DRAIN = 2'd3
  } arb_state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_M0   = 2'b01;
  localparam logic [1:0] OWN_M1   = 2'b10;

  // Width-independent part of a master request; the address travels separately.
  typedef struct packed {
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
  } wb_req_t;

  // Round-robin pick: on a tie, the master that did not own the bus last wins.
  function automatic logic [1:0] rr_pick(input logic c0, input logic c1,
                                         input logic [1:0] last);
    if (c0 && c1) return (last == OWN_M0) ? OWN_M1 : OWN_M0;
    else if (c0)  return OWN_M0;
    else if (c1)  return OWN_M1;
    else          return OWN_NONE;
  endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Bus watchdog: counts un-acked strobe cycles and flags expiry one edge early
// so the arbiter enters ERR in the cycle right after the count hits TIMEOUT.
module wb_arb_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       stb,
  input  logic       ack,
  output logic       expired,
  output logic [7:0] events
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  generate
    if (TIMEOUT > 0) begin : g_wd
      logic [CW-1:0] cnt;

      // An ack in the threshold cycle suppresses expiry.
      assign expired = stb && !ack && (cnt == CW'(TIMEOUT - 1));

      always_ff @(posedge clk or posedge reset) begin
        if (reset)                              cnt <= '0;
        else if (clr || ack)                    cnt <= '0;
        else if (stb && cnt != CW'(TIMEOUT))    cnt <= cnt + 1'b1;
      end
    end else begin : g_off
      assign expired = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          events <= 8'd0;
    else if (expired && events != 8'hFF) events <= events + 8'd1;
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin grant and a
// timeout watchdog that errors out a stalled owner and releases the slave.
module wb_rr_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int ADR_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [31:0]      m0_dat_i,
  input  logic [3:0]       m0_sel_i,
  input  logic             m0_we_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  output logic [31:0]      m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [31:0]      m1_dat_i,
  input  logic [3:0]       m1_sel_i,
  input  logic             m1_we_i,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  output logic [31:0]      m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [31:0]      s_dat_o,
  output logic [3:0]       s_sel_o,
  output logic             s_we_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  input  logic [31:0]      s_dat_i,
  input  logic             s_ack_i,
  output logic [1:0]       owner_o,
  output logic [7:0]       timeout_cnt_o
);
  import wb_arb_pkg::*;

  arb_state_e state, state_nx;
  logic [1:0] owner, owner_nx, last_owner, last_nx, other;
  logic [1:0][ADR_W-1:0] m_adr;
  wb_req_t [1:0] m_req;
  logic own_idx, own_cyc, oth_cyc, has_own, rel, expired, wd_clr;

  assign m_adr[0] = m0_adr_i;
  assign m_adr[1] = m1_adr_i;
  assign m_req[0] = '{dat: m0_dat_i, sel: m0_sel_i, we: m0_we_i, cyc: m0_cyc_i, stb: m0_stb_i};
  assign m_req[1] = '{dat: m1_dat_i, sel: m1_sel_i, we: m1_we_i, cyc: m1_cyc_i, stb: m1_stb_i};

  assign has_own = (owner != OWN_NONE);
  assign own_idx = owner[1];
  assign own_cyc = m_req[own_idx].cyc;
  assign oth_cyc = m_req[~own_idx].cyc;
  assign other   = (owner == OWN_M0) ? OWN_M1 : OWN_M0;

  // Slave request mux; cyc/stb are withheld outside BUSY so ERR/DRAIN free the slave.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    if (has_own) begin
      s_adr_o = m_adr[own_idx];
      s_dat_o = m_req[own_idx].dat;
      s_sel_o = m_req[own_idx].sel;
      s_we_o  = m_req[own_idx].we;
      if (state == S_BUSY) begin
        s_cyc_o = m_req[own_idx].cyc;
        s_stb_o = m_req[own_idx].stb;
      end
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = (state == S_BUSY) && (owner == OWN_M0) && s_ack_i;
  assign m1_ack_o = (state == S_BUSY) && (owner == OWN_M1) && s_ack_i;
  assign m0_err_o = (state == S_ERR)  && (owner == OWN_M0);
  assign m1_err_o = (state == S_ERR)  && (owner == OWN_M1);
  assign owner_o  = owner;

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last_owner;
    rel      = 1'b0;
    case (state)
      S_IDLE: begin
        if (m0_cyc_i || m1_cyc_i) begin
          state_nx = S_BUSY;
          owner_nx = rr_pick(m0_cyc_i, m1_cyc_i, last_owner);
        end
      end
      S_BUSY: begin
        if (expired)       state_nx = S_ERR;
        else if (!own_cyc) rel = 1'b1;
      end
      S_ERR:   state_nx = S_DRAIN;
      S_DRAIN: rel = !own_cyc;
      default: begin
        state_nx = S_IDLE;
        owner_nx = OWN_NONE;
      end
    endcase
    // Release hands straight to a waiting master, giving back-to-back cycles.
    if (rel) begin
      last_nx = owner;
      if (oth_cyc) begin
        owner_nx = other;
        state_nx = S_BUSY;
      end else begin
        owner_nx = OWN_NONE;
        state_nx = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      owner      <= OWN_NONE;
      last_owner <= OWN_M1;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_owner <= last_nx;
    end
  end

  assign wd_clr = (state != S_BUSY) || (owner_nx != owner);

  wb_arb_timeout #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .stb     (s_stb_o),
    .ack     (s_ack_i),
    .expired (expired),
    .events  (timeout_cnt_o)
  );

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Two-master, one-slave Wishbone classic arbiter with round-robin grant and a bus-timeout watchdog. It shares a single slave or slave segment between the LM32 instruction and data masters, or between the CPU and a second bus master such as a DMA or I2C sequencer. Without it, a slave that never acks stalls the whole SoC. With it, the stalled master gets `err_o` after a bounded wait and the slave is released.

## Interface
Parameters:
- `TIMEOUT`, default 1024: number of consecutive un-acked strobe cycles before an error is raised. 0 disables the watchdog.
- `ADR_W`, default 32: address width.

Ports:
- `clk` in 1: single system clock. All logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `m0_adr_i` in ADR_W; `m0_dat_i` in 32; `m0_sel_i` in 4; `m0_we_i`, `m0_cyc_i`, `m0_stb_i` in 1: master 0 request.
- `m0_dat_o` out 32; `m0_ack_o`, `m0_err_o` out 1: master 0 response.
- `m1_*`: same set as master 0, for master 1.
- `s_adr_o` out ADR_W; `s_dat_o` out 32; `s_sel_o` out 4; `s_we_o`, `s_cyc_o`, `s_stb_o` out 1: slave request.
- `s_dat_i` in 32; `s_ack_i` in 1: slave response.
- `owner_o` out 2: `00` none, `01` m0, `10` m1.
- `timeout_cnt_o` out 8: saturating count of timeout events.

## Operation
States and transitions:
- **IDLE**: no owner. At a clock edge with any `mX_cyc_i` high, move to **BUSY** and grant one master.
  - Only one master requesting: grant it.
  - Both requesting: grant the master that is not `last_owner`.
- **BUSY**: the owner's request signals are muxed to the `s_*` outputs. When the owner's `cyc_i` is sampled low:
  - `last_owner` is updated to that owner.
  - If the other master's `cyc_i` is high at the same edge, grant passes to it directly (stay in BUSY).
  - Otherwise move to IDLE.
- **ERR**: lasts exactly one cycle. The owner's `err_o` is 1, `s_cyc_o` and `s_stb_o` are 0. Always moves to **DRAIN**.
- **DRAIN**: `s_cyc_o` and `s_stb_o` stay 0 until the owner drops `cyc_i`. Then follow the same release and handover rule as BUSY.

Response routing:
- `m0_dat_o` and `m1_dat_o` both carry `s_dat_i` unconditionally.
- `ack_o` reaches only the owner: owner's `ack_o = s_ack_i` in BUSY, and it is 0 otherwise.
- The non-owner always sees `ack_o` and `err_o` at 0.
- `s_*` outputs are 0 whenever there is no owner.

Watchdog:
- The counter increments on each cycle with `s_stb_o` high and `s_ack_i` low.
- It clears on `s_ack_i` and on every grant change.
- When it reaches `TIMEOUT`, the next state is ERR and `timeout_cnt_o` increments, saturating at 255.
- If `s_ack_i` arrives in the same cycle the count reaches `TIMEOUT`, the ack wins: it is passed to the owner and no error is raised.

## Timing
- Reset values: state IDLE, `owner_o = 00`, `last_owner = m1` (so m0 wins the first tie), counter 0, `timeout_cnt_o = 0`, and all `s_*`, `ack_o` and `err_o` at 0.
- Grant latency: a request raised in cycle N appears on `s_*` in cycle N+1. Request muxing is combinational from the registered owner.
- Ack path: combinational from `s_ack_i` to the owner's `ack_o`, zero added latency.
- Handover: back-to-back. The new owner's request is on `s_*` the cycle after the old owner's `cyc` falls, with no idle cycle between.
- Error timing: stb rises in cycle N with no ack. The count reaches `TIMEOUT` at the edge ending cycle N+TIMEOUT−1, so `err_o` is high in cycle N+TIMEOUT.
- Requests raised while in ERR or DRAIN wait; the next grant follows the round-robin rule.
- Reset asserted mid-transaction: all outputs drop to their reset values immediately (asynchronously), and the slave request is abandoned.

## Structure
- Shared package `wb_arb_pkg` holds:
  - the state enum (IDLE, BUSY, ERR, DRAIN);
  - the owner encoding constants `OWN_NONE`, `OWN_M0`, `OWN_M1`.
- Sub-module `wb_arb_timeout`: the parameterised watchdog counter. It has inputs `clk`, `reset`, `clr`, `stb`, `ack` and outputs `expired` and the saturating `events` count. Counter width is `$clog2(TIMEOUT+1)`.
- The arbiter FSM and the request/response mux live in the top module.

## Test plan
- Single master: m0 does a read of 0x20000000 and the slave acks after 2 cycles. Expect `s_stb_o` high one cycle after m0 request, `m0_ack_o` in the slave's ack cycle, data passed through, `owner_o` 01 then 00.
- Tie after reset: both masters raise `cyc` in the same cycle. Expect m0 granted first. Both re-request. Expect m1 next, then m0, alternating strictly.
- Back-to-back: m1 waits while m0 owns the bus. When m0 drops `cyc`, expect m1's address on `s_adr_o` on the next cycle with no idle cycle.
- Timeout: with `TIMEOUT = 4`, the slave never acks. Expect `m0_err_o` high for one cycle exactly 4 cycles after stb rose, `s_cyc_o` low from then until m0 drops `cyc`, and `timeout_cnt_o` = 1. The non-owner never sees `ack_o` or `err_o`.
- Ack on threshold: with `TIMEOUT = 4`, the slave acks in the 4th wait cycle. Expect a normal ack, no `err_o`, and `timeout_cnt_o` unchanged.
- Reset mid-transfer: assert `reset` while m1 owns the bus. Expect all outputs at 0 immediately. After release, a tie is granted to m0.
